ram_wb: RTL and testbench

Write-side counterpart of the cpu15 RAM read decoder. On a store in the writeback stage it decodes the 8-bit address and updates one of eight 16-bit RAM words or the IO64 output port. IO64 is delivered to the external peripheral with a valid/ack handshake backed by a one-entry pending buffer. The eight RAM words and IO64 state are registered here and feed the read-side decoder directly.

---
 rtl/cpu15_pkg.sv | 29 ++
 rtl/io64_tx.sv | 88 ++++++++
 rtl/ram_wb.sv | 104 ++++++++++
 tb/tb_ram_wb.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu15_pkg.sv
// -----------------------------------------------------------------------------
// cpu15_pkg
// Shared constants for the cpu15 RAM read/write decoders.
//   - Address map: RAM words at 0x00..ADDR_RAM_LAST, IO64 output port, and
//     IO65 (input-only, so never a store target).
//   - IO64 transmit state encoding. Bit 0 means "IO64_OUT holds unconsumed
//     data" and bit 1 means "pending buffer occupied". This lets VALID and
//     BUSY come straight off the state flops.
// -----------------------------------------------------------------------------
package cpu15_pkg;

  localparam logic [7:0] ADDR_RAM_LAST = 8'h07;
  localparam logic [7:0] ADDR_IO64     = 8'h40;
  localparam logic [7:0] ADDR_IO65     = 8'h41;

  localparam int unsigned RAM_WORDS  = 8;
  localparam int unsigned DATA_WIDTH = 16;

  typedef enum logic [1:0] {
    IO64_IDLE = 2'b00,  // nothing to deliver
    IO64_SENT = 2'b01,  // IO64_OUT valid, buffer empty
    IO64_FULL = 2'b11   // IO64_OUT valid, buffer holds the next word
  } io64_state_e;

  function automatic logic is_ram_addr(input logic [7:0] addr);
    return (addr <= ADDR_RAM_LAST);
  endfunction

endpackage

// File: rtl/io64_tx.sv
// -----------------------------------------------------------------------------
// io64_tx
// IO64 output port with a valid/ack handshake and a one-entry pending buffer.
// Ports:
//   CLK_WB    in   writeback clock
//   RESET     in   synchronous active-high reset
//   i_store   in   decoded IO64 store this cycle
//   i_data    in   store data
//   i_ack     in   peripheral consumed o_data (one-cycle pulse)
//   o_data    out  registered IO64 output word
//   o_valid   out  o_data holds unconsumed data
//   o_busy    out  pending buffer occupied
//   o_drop    out  an IO64 store is being dropped this cycle (buffer full)
// -----------------------------------------------------------------------------
module io64_tx
  import cpu15_pkg::*;
(
  input  logic                  CLK_WB,
  input  logic                  RESET,
  input  logic                  i_store,
  input  logic [DATA_WIDTH-1:0] i_data,
  input  logic                  i_ack,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic                  o_valid,
  output logic                  o_busy,
  output logic                  o_drop
);

  io64_state_e           r_state, w_state_nxt;
  logic [DATA_WIDTH-1:0] r_out,   w_out_nxt;
  logic [DATA_WIDTH-1:0] r_pend,  w_pend_nxt;

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values of its peers, independent of block order.
  always_ff @(posedge CLK_WB) begin
    if (RESET) begin
      r_state <= IO64_IDLE;
      r_out   <= '0;
      r_pend  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_out   <= w_out_nxt;
      r_pend  <= w_pend_nxt;
    end
  end

  // NOTE: every output of this block gets a default first; otherwise any
  // path that skips an assignment would infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_out_nxt   = r_out;
    w_pend_nxt  = r_pend;
    o_drop      = 1'b0;
    unique case (r_state)
      IO64_IDLE: begin
        if (i_store) begin
          w_out_nxt   = i_data;
          w_state_nxt = IO64_SENT;
        end
      end
      IO64_SENT: begin
        if (i_ack && i_store) begin
          // Current word consumed and replaced on the same edge.
          w_out_nxt = i_data;
        end else if (i_ack) begin
          w_state_nxt = IO64_IDLE;
        end else if (i_store) begin
          w_pend_nxt  = i_data;
          w_state_nxt = IO64_FULL;
        end
      end
      IO64_FULL: begin
        // A store here is dropped even when ACK frees the buffer this edge.
        o_drop = i_store;
        if (i_ack) begin
          w_out_nxt   = r_pend;
          w_state_nxt = IO64_SENT;
        end
      end
      default: w_state_nxt = IO64_IDLE;
    endcase
  end

  assign o_data  = r_out;
  assign o_valid = r_state[0];
  assign o_busy  = r_state[1];

endmodule

// File: rtl/ram_wb.sv
// -----------------------------------------------------------------------------
// ram_wb
// Writeback-stage store decoder: updates one of eight 16-bit RAM words or the
// IO64 output port. All outputs are registered.
// Ports:
//   CLK_WB, RESET          clock, synchronous active-high reset
//   RAM_WEN                store request
//   RAM_AD_IN[7:0]         store address (0x00-0x07 RAM, 0x40 IO64)
//   RAM_DATA_IN[15:0]      store data
//   IO64_ACK               peripheral consumed IO64_OUT
//   RAM_0..RAM_7[15:0]     RAM words
//   IO64_OUT[15:0]         IO64 output data
//   IO64_VALID             IO64_OUT holds unconsumed data
//   RAM_BUSY               IO64 pending buffer occupied
//   WR_ERR                 sticky unmapped/dropped-store flag
// Configuration: define RAM_WB_ERR_EN to build the WR_ERR logic; otherwise
// WR_ERR is tied low.
// -----------------------------------------------------------------------------
module ram_wb
  import cpu15_pkg::*;
(
  input  logic        CLK_WB,
  input  logic        RESET,
  input  logic        RAM_WEN,
  input  logic [7:0]  RAM_AD_IN,
  input  logic [15:0] RAM_DATA_IN,
  input  logic        IO64_ACK,
  output logic [15:0] RAM_0,
  output logic [15:0] RAM_1,
  output logic [15:0] RAM_2,
  output logic [15:0] RAM_3,
  output logic [15:0] RAM_4,
  output logic [15:0] RAM_5,
  output logic [15:0] RAM_6,
  output logic [15:0] RAM_7,
  output logic [15:0] IO64_OUT,
  output logic        IO64_VALID,
  output logic        RAM_BUSY,
  output logic        WR_ERR
);

  logic [DATA_WIDTH-1:0] r_ram [RAM_WORDS];

  logic w_ram_store;
  logic w_io64_store;
  logic w_io64_drop;

  assign w_ram_store  = RAM_WEN && is_ram_addr(RAM_AD_IN);
  assign w_io64_store = RAM_WEN && (RAM_AD_IN == ADDR_IO64);

  // NOTE: these words are architecturally visible outputs with a defined
  // reset value, so unlike a plain RAM macro they must be reset.
  always_ff @(posedge CLK_WB) begin
    if (RESET) begin
      for (int i = 0; i < RAM_WORDS; i++) r_ram[i] <= '0;
    end else if (w_ram_store) begin
      r_ram[RAM_AD_IN[2:0]] <= RAM_DATA_IN;
    end
  end

  assign RAM_0 = r_ram[0];
  assign RAM_1 = r_ram[1];
  assign RAM_2 = r_ram[2];
  assign RAM_3 = r_ram[3];
  assign RAM_4 = r_ram[4];
  assign RAM_5 = r_ram[5];
  assign RAM_6 = r_ram[6];
  assign RAM_7 = r_ram[7];

  io64_tx u_io64_tx (
    .CLK_WB  (CLK_WB),
    .RESET   (RESET),
    .i_store (w_io64_store),
    .i_data  (RAM_DATA_IN),
    .i_ack   (IO64_ACK),
    .o_data  (IO64_OUT),
    .o_valid (IO64_VALID),
    .o_busy  (RAM_BUSY),
    .o_drop  (w_io64_drop)
  );

`ifdef RAM_WB_ERR_EN
  logic w_unmapped_store;
  logic r_wr_err;

  // IO65 is input-only, so it falls into the unmapped set for stores.
  assign w_unmapped_store = RAM_WEN && !w_ram_store && !w_io64_store;

  always_ff @(posedge CLK_WB) begin
    if (RESET) begin
      r_wr_err <= 1'b0;
    end else if (w_unmapped_store || w_io64_drop) begin
      r_wr_err <= 1'b1;
    end
  end

  assign WR_ERR = r_wr_err;
`else
  logic w_unused_drop;
  assign w_unused_drop = w_io64_drop;
  assign WR_ERR        = 1'b0;
`endif

endmodule

// File: tb/tb_ram_wb.sv
// -----------------------------------------------------------------------------
// tb_ram_wb
// Self-checking bench for ram_wb. The reference model treats IO64 as a FIFO
// of at most two undelivered words: the head is IO64_OUT, VALID means
// non-empty, BUSY means two entries. When the FIFO is empty, IO64_OUT keeps
// the last delivered word.
// -----------------------------------------------------------------------------
module tb_ram_wb;

`ifdef RAM_WB_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        RESET = 1'b0;
  logic        RAM_WEN = 1'b0;
  logic [7:0]  RAM_AD_IN = '0;
  logic [15:0] RAM_DATA_IN = '0;
  logic        IO64_ACK = 1'b0;
  logic [15:0] ram_o [8];
  logic [15:0] IO64_OUT;
  logic        IO64_VALID;
  logic        RAM_BUSY;
  logic        WR_ERR;

  always #5 clk = ~clk;

  ram_wb dut (
    .CLK_WB      (clk),
    .RESET       (RESET),
    .RAM_WEN     (RAM_WEN),
    .RAM_AD_IN   (RAM_AD_IN),
    .RAM_DATA_IN (RAM_DATA_IN),
    .IO64_ACK    (IO64_ACK),
    .RAM_0       (ram_o[0]),
    .RAM_1       (ram_o[1]),
    .RAM_2       (ram_o[2]),
    .RAM_3       (ram_o[3]),
    .RAM_4       (ram_o[4]),
    .RAM_5       (ram_o[5]),
    .RAM_6       (ram_o[6]),
    .RAM_7       (ram_o[7]),
    .IO64_OUT    (IO64_OUT),
    .IO64_VALID  (IO64_VALID),
    .RAM_BUSY    (RAM_BUSY),
    .WR_ERR      (WR_ERR)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state.
  logic [15:0] m_ram [8];
  logic [15:0] m_q [$];
  logic [15:0] m_last;
  bit          m_err;

  function automatic logic [15:0] exp_out();
    return (m_q.size() > 0) ? m_q[0] : m_last;
  endfunction

  function automatic logic exp_err();
    return ERR_EN & m_err;
  endfunction

  task automatic model_edge(input bit rst, input bit wen, input logic [7:0] ad,
                            input logic [15:0] data, input bit ack);
    int pre;
    if (rst) begin
      for (int i = 0; i < 8; i++) m_ram[i] = '0;
      m_q.delete();
      m_last = '0;
      m_err  = 1'b0;
    end else begin
      pre = m_q.size();
      if (ack && pre > 0) m_last = m_q.pop_front();
      if (wen) begin
        if (ad <= 8'h07)       m_ram[ad[2:0]] = data;
        else if (ad == 8'h40) begin
          if (pre < 2) m_q.push_back(data);
          else         m_err = 1'b1;
        end else              m_err = 1'b1;
      end
    end
  endtask

  // Drive one cycle, advance the model, and leave time 1 after the edge.
  task automatic tick(input bit rst, input bit wen, input logic [7:0] ad,
                      input logic [15:0] data, input bit ack);
    RESET       = rst;
    RAM_WEN     = wen;
    RAM_AD_IN   = ad;
    RAM_DATA_IN = data;
    IO64_ACK    = ack;
    @(posedge clk);
    model_edge(rst, wen, ad, data, ack);
    #1;
    RESET    = 1'b0;
    RAM_WEN  = 1'b0;
    IO64_ACK = 1'b0;
  endtask

  task automatic test_reset();
    tick(1, 0, 8'h00, 16'h0, 0);
    for (int i = 0; i < 8; i++) begin
      n_tests++;
      if (ram_o[i] !== 16'h0) begin
        n_fail++;
        $display("FAIL reset_ram%0d: got %h expected 0000", i, ram_o[i]);
      end
    end
    n_tests++;
    if ({IO64_OUT, IO64_VALID, RAM_BUSY, WR_ERR} !== 19'h0) begin
      n_fail++;
      $display("FAIL reset_io: out=%h valid=%b busy=%b err=%b expected all 0",
               IO64_OUT, IO64_VALID, RAM_BUSY, WR_ERR);
    end
  endtask

  task automatic test_ram_store();
    tick(1, 1, 8'h03, 16'h1234, 0);
    tick(0, 1, 8'h03, 16'h1234, 0);
    for (int i = 0; i < 8; i++) begin
      n_tests++;
      if (ram_o[i] !== ((i == 3) ? 16'h1234 : 16'h0)) begin
        n_fail++;
        $display("FAIL ram_store_ram%0d: got %h expected %h", i, ram_o[i],
                 (i == 3) ? 16'h1234 : 16'h0);
      end
    end
    n_tests++;
    if (IO64_VALID !== 1'b0) begin
      n_fail++;
      $display("FAIL ram_store_valid: got %b expected 0", IO64_VALID);
    end
  endtask

  task automatic test_io64_handshake();
    tick(0, 1, 8'h40, 16'hAAAA, 0);
    n_tests++;
    if ({IO64_OUT, IO64_VALID, RAM_BUSY} !== {16'hAAAA, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL hs_first: out=%h v=%b b=%b expected aaaa 1 0", IO64_OUT, IO64_VALID, RAM_BUSY);
    end
    tick(0, 1, 8'h40, 16'hBBBB, 0);
    n_tests++;
    if ({IO64_OUT, IO64_VALID, RAM_BUSY} !== {16'hAAAA, 1'b1, 1'b1}) begin
      n_fail++;
      $display("FAIL hs_full: out=%h v=%b b=%b expected aaaa 1 1", IO64_OUT, IO64_VALID, RAM_BUSY);
    end
    tick(0, 0, 8'h00, 16'h0, 1);
    n_tests++;
    if ({IO64_OUT, IO64_VALID, RAM_BUSY} !== {16'hBBBB, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL hs_drain: out=%h v=%b b=%b expected bbbb 1 0", IO64_OUT, IO64_VALID, RAM_BUSY);
    end
    tick(0, 0, 8'h00, 16'h0, 1);
    n_tests++;
    if ({IO64_OUT, IO64_VALID, RAM_BUSY} !== {16'hBBBB, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL hs_idle: out=%h v=%b b=%b expected bbbb 0 0", IO64_OUT, IO64_VALID, RAM_BUSY);
    end
    // ACK in IDLE is ignored.
    tick(0, 0, 8'h00, 16'h0, 1);
    n_tests++;
    if ({IO64_OUT, IO64_VALID, RAM_BUSY} !== {16'hBBBB, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL hs_idle_ack: out=%h v=%b b=%b expected bbbb 0 0", IO64_OUT, IO64_VALID, RAM_BUSY);
    end
  endtask

  task automatic test_full_drop();
    tick(1, 0, 8'h00, 16'h0, 0);
    tick(0, 1, 8'h40, 16'h1111, 0);
    tick(0, 1, 8'h40, 16'h2222, 0);
    tick(0, 1, 8'h40, 16'hCCCC, 0);
    n_tests++;
    if ({IO64_OUT, IO64_VALID, RAM_BUSY, WR_ERR} !== {16'h1111, 1'b1, 1'b1, ERR_EN}) begin
      n_fail++;
      $display("FAIL drop_state: out=%h v=%b b=%b err=%b expected 1111 1 1 %b",
               IO64_OUT, IO64_VALID, RAM_BUSY, WR_ERR, ERR_EN);
    end
    // Drop with ACK on the same edge: pending is delivered, new word is lost.
    tick(0, 1, 8'h40, 16'hDDDD, 1);
    n_tests++;
    if ({IO64_OUT, IO64_VALID, RAM_BUSY} !== {16'h2222, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL drop_pending: out=%h v=%b b=%b expected 2222 1 0", IO64_OUT, IO64_VALID, RAM_BUSY);
    end
    tick(0, 0, 8'h00, 16'h0, 1);
    n_tests++;
    if (IO64_VALID !== 1'b0) begin
      n_fail++;
      $display("FAIL drop_empty: valid=%b expected 0", IO64_VALID);
    end
  endtask

  task automatic test_unmapped();
    tick(1, 0, 8'h00, 16'h0, 0);
    tick(0, 1, 8'h41, 16'h0001, 0);
    tick(0, 1, 8'h08, 16'h0002, 0);
    for (int i = 0; i < 8; i++) begin
      n_tests++;
      if (ram_o[i] !== 16'h0) begin
        n_fail++;
        $display("FAIL unmapped_ram%0d: got %h expected 0000", i, ram_o[i]);
      end
    end
    n_tests++;
    if ({IO64_OUT, IO64_VALID, WR_ERR} !== {16'h0, 1'b0, ERR_EN}) begin
      n_fail++;
      $display("FAIL unmapped_io: out=%h v=%b err=%b expected 0000 0 %b",
               IO64_OUT, IO64_VALID, WR_ERR, ERR_EN);
    end
    tick(0, 1, 8'h00, 16'h7777, 0);
    tick(0, 1, 8'h40, 16'h8888, 1);
    n_tests++;
    if ({ram_o[0], WR_ERR} !== {16'h7777, ERR_EN}) begin
      n_fail++;
      $display("FAIL unmapped_sticky: ram0=%h err=%b expected 7777 %b", ram_o[0], WR_ERR, ERR_EN);
    end
    tick(1, 0, 8'h00, 16'h0, 0);
    n_tests++;
    if (WR_ERR !== 1'b0) begin
      n_fail++;
      $display("FAIL unmapped_clear: err=%b expected 0", WR_ERR);
    end
  endtask

  task automatic test_ack_store_same_edge();
    tick(0, 1, 8'h40, 16'h4444, 0);
    tick(0, 1, 8'h40, 16'h5555, 1);
    n_tests++;
    if ({IO64_OUT, IO64_VALID, RAM_BUSY} !== {16'h5555, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL same_edge: out=%h v=%b b=%b expected 5555 1 0", IO64_OUT, IO64_VALID, RAM_BUSY);
    end
    // Streaming: one word per cycle with ACK every cycle, never BUSY.
    for (int k = 0; k < 6; k++) begin
      tick(0, 1, 8'h40, 16'h6000 + 16'(k), 1);
      n_tests++;
      if ({IO64_OUT, IO64_VALID, RAM_BUSY} !== {16'h6000 + 16'(k), 1'b1, 1'b0}) begin
        n_fail++;
        $display("FAIL stream%0d: out=%h v=%b b=%b expected %h 1 0", k,
                 IO64_OUT, IO64_VALID, RAM_BUSY, 16'h6000 + 16'(k));
      end
    end
    tick(0, 0, 8'h00, 16'h0, 1);
  endtask

  task automatic test_reset_in_full();
    tick(0, 1, 8'h05, 16'h9999, 0);
    tick(0, 1, 8'h40, 16'hA1A1, 0);
    tick(0, 1, 8'h40, 16'hB2B2, 0);
    tick(1, 1, 8'h40, 16'hC3C3, 1);
    n_tests++;
    if ({ram_o[5], IO64_OUT, IO64_VALID, RAM_BUSY, WR_ERR} !== 35'h0) begin
      n_fail++;
      $display("FAIL reset_full: ram5=%h out=%h v=%b b=%b err=%b expected all 0",
               ram_o[5], IO64_OUT, IO64_VALID, RAM_BUSY, WR_ERR);
    end
    tick(0, 0, 8'h00, 16'h0, 1);
    n_tests++;
    if ({IO64_OUT, IO64_VALID, RAM_BUSY} !== 18'h0) begin
      n_fail++;
      $display("FAIL reset_full_ack: out=%h v=%b b=%b expected 0000 0 0",
               IO64_OUT, IO64_VALID, RAM_BUSY);
    end
  endtask

  task automatic test_random();
    logic [7:0]  ad;
    logic [15:0] data;
    bit          rst, wen, ack;
    for (int c = 0; c < 400; c++) begin
      case ($urandom_range(0, 3))
        0, 1:    ad = 8'($urandom_range(0, 7));
        2:       ad = ($urandom_range(0, 1) != 0) ? 8'h40 : 8'h41;
        default: ad = 8'($urandom);
      endcase
      data = 16'($urandom);
      rst  = ($urandom_range(0, 59) == 0);
      wen  = ($urandom_range(0, 3) != 0);
      ack  = ($urandom_range(0, 2) == 0);
      tick(rst, wen, ad, data, ack);
      for (int i = 0; i < 8; i++) begin
        n_tests++;
        if (ram_o[i] !== m_ram[i]) begin
          n_fail++;
          $display("FAIL rand_c%0d_ram%0d: got %h expected %h", c, i, ram_o[i], m_ram[i]);
        end
      end
      n_tests++;
      if ({IO64_OUT, IO64_VALID, RAM_BUSY, WR_ERR} !==
          {exp_out(), m_q.size() > 0, m_q.size() == 2, exp_err()}) begin
        n_fail++;
        $display("FAIL rand_c%0d_io: out=%h v=%b b=%b err=%b expected %h %b %b %b", c,
                 IO64_OUT, IO64_VALID, RAM_BUSY, WR_ERR,
                 exp_out(), m_q.size() > 0, m_q.size() == 2, exp_err());
      end
    end
  endtask

  initial begin
    test_reset();
    test_ram_store();
    test_io64_handshake();
    test_full_drop();
    test_unmapped();
    test_ack_store_same_edge();
    test_reset_in_full();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
